quad_step_decoder: RTL and testbench

//   Upstream stage of the n-bit up/down counter. Turns two asynchronous quadrature

---
 rtl/qd_pkg.sv | 26 ++
 rtl/qd_sync_filter.sv | 46 ++++
 rtl/quad_step_decoder.sv | 100 ++++++++++
 tb/tb_quad_step_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/qd_pkg.sv
// Shared encodings for the quadrature step decoder: Gray step codes, FSM states
// and the forward-step successor function.
package qd_pkg;

  localparam logic [1:0] QD_S0 = 2'b00;
  localparam logic [1:0] QD_S1 = 2'b01;
  localparam logic [1:0] QD_S2 = 2'b11;
  localparam logic [1:0] QD_S3 = 2'b10;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } qd_state_e;

  // Next code in the forward direction, {a,b}: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] qd_next(input logic [1:0] s);
    case (s)
      QD_S0:   qd_next = QD_S1;
      QD_S1:   qd_next = QD_S2;
      QD_S2:   qd_next = QD_S3;
      default: qd_next = QD_S0;
    endcase
  endfunction

endpackage

// File: rtl/qd_sync_filter.sv
// One quadrature channel: 2-flop synchroniser followed by a stability filter that
// only moves filt_out once the synced value has differed for FILT_CYCLES edges.
module qd_sync_filter #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic raw,
  output logic filt_out
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          sync;

  assign sync = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt      <= '0;
      filt_out <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (load) begin
        filt_out <= sync;
        cnt      <= '0;
      end else if (sync != filt_out) begin
        // the edge where cnt sits at the max is the FILT_CYCLES-th differing sample
        if (cnt == CNT_MAX) begin
          filt_out <= sync;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to up/down step pulses: per-channel sync+filter, start-up FSM,
// x4 Gray decode, direction latch and saturating illegal-transition counter.
module quad_step_decoder
  import qd_pkg::*;
#(
  parameter int FILT_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             quad_a,
  input  logic             quad_b,
  output logic             up,
  output logic             down,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             a_filt,
  output logic             b_filt
);

  qd_state_e  state, state_d;
  logic       prime_done;
  logic       armed;
  logic       load;
  logic [1:0] raw_v, filt_v, prev;
  logic       step_up, step_dn, step_err, fire;

  assign raw_v  = {quad_a, quad_b};
  assign a_filt = filt_v[1];
  assign b_filt = filt_v[0];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    qd_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .raw      (raw_v[ch]),
      .filt_out (filt_v[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIME;
      prime_done <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_d;
      prime_done <= (state == PRIME) && !prime_done;
      armed      <= (state == RUN);
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      PRIME:   if (prime_done) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  // prev still holds the pre-load value during the first RUN cycle, so decode waits one cycle
  always_comb begin
    step_up  = (qd_next(prev) == filt_v);
    step_dn  = (qd_next(filt_v) == prev);
    step_err = ((prev ^ filt_v) == 2'b11);
    fire     = en && (state == RUN) && armed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      err       <= 1'b0;
      dir       <= 1'b0;
      err_count <= '0;
    end else begin
      prev <= filt_v;
      up   <= fire && step_up;
      down <= fire && step_dn;
      err  <= fire && step_err;
      if (fire && step_up)
        dir <= 1'b1;
      else if (fire && step_dn)
        dir <= 1'b0;
      if (fire && step_err && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: table of held pin patterns with expected
// pulse counts, plus hand sequences for glitch, saturation, reset and enable cases.
module tb_quad_step_decoder;

  localparam int FILT_CYCLES = 4;
  localparam int ERR_W       = 8;

  logic             clk = 1'b0;
  logic             rst, en, quad_a, quad_b;
  logic             up, down, dir, err, a_filt, b_filt;
  logic [ERR_W-1:0] err_count;

  quad_step_decoder #(.FILT_CYCLES(FILT_CYCLES), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .up        (up),
    .down      (down),
    .dir       (dir),
    .err       (err),
    .err_count (err_count),
    .a_filt    (a_filt),
    .b_filt    (b_filt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tot_up = 0, tot_dn = 0, tot_err = 0, tot_both = 0, tot_af = 0, last_up_cyc = -1;
  always @(negedge clk) begin
    if (up) begin
      tot_up++;
      last_up_cyc = cyc;
    end
    if (down)       tot_dn++;
    if (err)        tot_err++;
    if (up && down) tot_both++;
    if (a_filt)     tot_af++;
  end

  int n_chk = 0, n_fail = 0;
  int s_up, s_dn, s_err, s_af, t0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic snap();
    s_up  = tot_up;
    s_dn  = tot_dn;
    s_err = tot_err;
    s_af  = tot_af;
  endtask

  task automatic chk_pulses(input string nm, input int eu, input int ed, input int ee);
    chk({nm, "_up"},   tot_up  - s_up,  eu);
    chk({nm, "_down"}, tot_dn  - s_dn,  ed);
    chk({nm, "_err"},  tot_err - s_err, ee);
  endtask

  // entered and left at posedge+1
  task automatic drive(input logic a, input logic b, input int hold);
    quad_a = a;
    quad_b = b;
    t0     = cyc;
    snap();
    repeat (hold) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   up_n;
    int   dn_n;
    int   err_n;
    int   dir;
    int   ecnt;
    int   lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst = 1'b1; en = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up",   int'(up),        0);
    chk("rst_down", int'(down),      0);
    chk("rst_dir",  int'(dir),       0);
    chk("rst_err",  int'(err),       0);
    chk("rst_ecnt", int'(err_count), 0);
    chk("rst_af",   int'(a_filt),    0);
    chk("rst_bf",   int'(b_filt),    0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // forward, reverse, then two illegal double changes
    tbl[0] = '{1'b0, 1'b1, 10, 1, 0, 0, 1, 0,  7};
    tbl[1] = '{1'b1, 1'b1, 10, 1, 0, 0, 1, 0, -1};
    tbl[2] = '{1'b1, 1'b0, 10, 1, 0, 0, 1, 0, -1};
    tbl[3] = '{1'b0, 1'b0, 10, 1, 0, 0, 1, 0, -1};
    tbl[4] = '{1'b1, 1'b0, 10, 0, 1, 0, 0, 0, -1};
    tbl[5] = '{1'b1, 1'b1, 10, 0, 1, 0, 0, 0, -1};
    tbl[6] = '{1'b0, 1'b1, 10, 0, 1, 0, 0, 0, -1};
    tbl[7] = '{1'b0, 1'b0, 10, 0, 1, 0, 0, 0, -1};
    tbl[8] = '{1'b1, 1'b1, 10, 0, 0, 1, 0, 1, -1};
    tbl[9] = '{1'b0, 1'b0, 10, 0, 0, 1, 0, 2, -1};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].hold);
      chk_pulses($sformatf("vec%0d", i), tbl[i].up_n, tbl[i].dn_n, tbl[i].err_n);
      chk($sformatf("vec%0d_dir", i),  int'(dir),       tbl[i].dir);
      chk($sformatf("vec%0d_ecnt", i), int'(err_count), tbl[i].ecnt);
      chk($sformatf("vec%0d_filt", i), int'({a_filt, b_filt}), int'({tbl[i].a, tbl[i].b}));
      if (tbl[i].lat >= 0)
        chk($sformatf("vec%0d_latency", i), last_up_cyc - t0, tbl[i].lat);
    end

    // 3-cycle glitch on A must not reach the filter
    snap();
    quad_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    quad_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_af_high", tot_af - s_af, 0);
    chk_pulses("glitch", 0, 0, 0);

    // 298 more double changes: 300 total, counter pinned at 255
    snap();
    for (int i = 0; i < 298; i++) begin
      quad_a = ~quad_a;
      quad_b = ~quad_b;
      repeat (8) @(posedge clk);
    end
    #1;
    chk_pulses("sat", 0, 0, 298);
    chk("sat_ecnt", int'(err_count), 255);

    // pins high through reset, then release
    quad_a = 1'b1; quad_b = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst11_ecnt", int'(err_count), 0);
    rst = 1'b0;
    snap();
    repeat (12) @(posedge clk);
    #1;
    chk_pulses("rst11_quiet", 0, 0, 0);
    chk("rst11_filt", int'({a_filt, b_filt}), 3);
    drive(1'b1, 1'b0, 10);
    chk_pulses("rst11_step", 1, 0, 0);
    chk("rst11_dir", int'(dir), 1);

    // enable low through three forward steps: filters track, nothing pulses
    en = 1'b0;
    snap();
    quad_a = 1'b0; quad_b = 1'b0;
    repeat (10) @(posedge clk);
    quad_b = 1'b1;
    repeat (10) @(posedge clk);
    quad_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_pulses("en0", 0, 0, 0);
    chk("en0_filt", int'({a_filt, b_filt}), 3);
    chk("en0_dir", int'(dir), 1);
    en = 1'b1;
    snap();
    repeat (10) @(posedge clk);
    #1;
    chk_pulses("en_rise", 0, 0, 0);
    drive(1'b0, 1'b1, 10);
    chk_pulses("en1_rev", 0, 1, 0);
    chk("en1_dir", int'(dir), 0);
    drive(1'b1, 0, 10);
    chk_pulses("en1_err", 0, 0, 1);
    chk("en1_ecnt", int'(err_count), 1);

    // reset in the middle of a pending filter count
    quad_a = 1'b0; quad_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_up",   int'(up),        0);
    chk("mid_rst_down", int'(down),      0);
    chk("mid_rst_err",  int'(err),       0);
    chk("mid_rst_dir",  int'(dir),       0);
    chk("mid_rst_ecnt", int'(err_count), 0);
    chk("mid_rst_filt", int'({a_filt, b_filt}), 0);
    rst = 1'b0;
    snap();
    repeat (12) @(posedge clk);
    #1;
    chk_pulses("post_rst", 0, 0, 0);

    chk("up_down_overlap", tot_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
